// File: rtl/lcd_fifo_pkg.sv
// Shared defaults and parameter-legality check for the LCD pixel FIFO family.
package lcd_fifo_pkg;

    localparam int DEF_DATA_WIDTH       = 16;
    localparam int DEF_DEPTH_WIDTH      = 11;
    localparam int DEF_ALMOST_FULL_NUM  = 640;
    localparam int DEF_ALMOST_EMPTY_NUM = 4;

    function automatic bit params_legal(input int data_width, input int depth_width,
                                        input int fwft, input int af_num, input int ae_num);
        int depth;
        depth = 1 << depth_width;
        return (data_width >= 1) && (data_width <= 1152) &&
               (depth_width >= 4) && (depth_width <= 20) &&
               (fwft == 0 || fwft == 1) &&
               (af_num >= 1) && (af_num <= depth) &&
               (ae_num >= 0) && (ae_num < depth);
    endfunction

endpackage

// File: rtl/lcd_pix_fifo_ram.sv
// Simple dual-port storage: one write port, one read port that is either
// registered (with reset on the output register) or asynchronous.
module lcd_pix_fifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter bit ASYNC_READ = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    // Array is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    generate
        if (ASYNC_READ) begin : g_async
            logic w_unused;
            assign w_unused  = i_rd_en ^ rst_n;
            assign o_rd_data = r_mem[i_rd_addr];
        end else begin : g_sync
            logic [DATA_WIDTH-1:0] r_rd_data;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       r_rd_data <= '0;
                else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
            end
            assign o_rd_data = r_rd_data;
        end
    endgenerate

endmodule

// File: rtl/lcd_pix_fifo.sv
// Single-clock pixel FIFO: pointer, occupancy and flag logic around a
// dual-port RAM, with standard or first-word-fall-through read timing.
module lcd_pix_fifo
    import lcd_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int DEPTH_WIDTH      = DEF_DEPTH_WIDTH,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
    parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   water_level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int            DEPTH    = 1 << DEPTH_WIDTH;
    localparam int            PW       = DEPTH_WIDTH + 1;
    localparam logic [PW-1:0] LVL_FULL = PW'(DEPTH);
    localparam logic [PW-1:0] LVL_AF   = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0] LVL_AE   = PW'(ALMOST_EMPTY_NUM);

    if (!params_legal(DATA_WIDTH, DEPTH_WIDTH, FWFT, ALMOST_FULL_NUM, ALMOST_EMPTY_NUM)) begin : g_bad_params
        $error("lcd_pix_fifo: illegal parameter combination");
    end

    logic [PW-1:0]         r_wr_ptr, r_rd_ptr, r_level;
    logic                  r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
    logic                  w_wr_acc, w_rd_acc;
    logic [PW-1:0]         w_wr_ptr_nxt, w_rd_ptr_nxt, w_level_nxt;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // Handshake: a write is taken on an edge where wr_en=1 and full=0, a read
    // where rd_en=1 and empty=0; flags are the registered start-of-cycle values
    // and flush suppresses both.
    assign w_wr_acc     = wr_en & ~r_full  & ~flush;
    assign w_rd_acc     = rd_en & ~r_empty & ~flush;
    assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_acc);
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_acc);
    // Pointers wrap modulo 2*DEPTH, so their difference is the exact occupancy.
    assign w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == LVL_FULL);
            r_empty  <= (w_level_nxt == '0);
            r_afull  <= (w_level_nxt >= LVL_AF);
            r_aempty <= (w_level_nxt <= LVL_AE);
            if (wr_en && r_full)  r_ovf <= 1'b1;
            if (rd_en && r_empty) r_unf <= 1'b1;
        end
    end

    lcd_pix_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_WIDTH),
        .ASYNC_READ (FWFT != 0)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[DEPTH_WIDTH-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr[DEPTH_WIDTH-1:0]),
        .o_rd_data (w_ram_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Last word shown while non-empty, so rd_data holds once the FIFO empties.
            logic [DATA_WIDTH-1:0] r_hold;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)        r_hold <= '0;
                else if (!r_empty) r_hold <= w_ram_rdata;
            end
            assign rd_data = r_empty ? r_hold : w_ram_rdata;
        end else begin : g_std
            assign rd_data = w_ram_rdata;
        end
    endgenerate

    assign full         = r_full;
    assign almost_full  = r_afull;
    assign empty        = r_empty;
    assign almost_empty = r_aempty;
    assign water_level  = r_level;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_lcd_pix_fifo.sv
// Bench for lcd_pix_fifo: a standard-read and an FWFT instance share stimulus
// and are compared against a queue-based model plus directed vector tables.
module tb_lcd_pix_fifo;

    localparam int DW  = 16;
    localparam int DWD = 4;
    localparam int DEP = 16;
    localparam int AFN = 12;
    localparam int AEN = 2;

    logic clk, rst_n, flush, wr_en, rd_en;
    logic [DW-1:0] wr_data;

    logic          d0_full, d0_afull, d0_empty, d0_aempty, d0_ovf, d0_unf;
    logic [DW-1:0] d0_rd_data;
    logic [DWD:0]  d0_level;
    logic          d1_full, d1_afull, d1_empty, d1_aempty, d1_ovf, d1_unf;
    logic [DW-1:0] d1_rd_data;
    logic [DWD:0]  d1_level;

    lcd_pix_fifo #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DWD), .FWFT(0),
                   .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(d0_full), .almost_full(d0_afull), .rd_en(rd_en), .rd_data(d0_rd_data),
        .empty(d0_empty), .almost_empty(d0_aempty), .water_level(d0_level),
        .overflow(d0_ovf), .underflow(d0_unf));

    lcd_pix_fifo #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DWD), .FWFT(1),
                   .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) u_dut_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(d1_full), .almost_full(d1_afull), .rd_en(rd_en), .rd_data(d1_rd_data),
        .empty(d1_empty), .almost_empty(d1_aempty), .water_level(d1_level),
        .overflow(d1_ovf), .underflow(d1_unf));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard / reference model
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_rd;
    bit            m_ovf, m_unf;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rd  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input bit f, input bit w, input bit r, input logic [DW-1:0] d);
        bit was_full, was_empty;
        if (f) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_full  = (exp_q.size() == DEP);
            was_empty = (exp_q.size() == 0);
            if (r) begin
                if (was_empty) m_unf = 1'b1;
                else           m_rd  = exp_q.pop_front();
            end
            if (w) begin
                if (was_full) m_ovf = 1'b1;
                else          exp_q.push_back(d);
            end
        end
    endtask

    task automatic check_model(input string tag);
        int lvl;
        lvl = exp_q.size();
        chk({tag, ".level"},   int'(d0_level),   lvl);
        chk({tag, ".full"},    int'(d0_full),    int'(lvl == DEP));
        chk({tag, ".afull"},   int'(d0_afull),   int'(lvl >= AFN));
        chk({tag, ".empty"},   int'(d0_empty),   int'(lvl == 0));
        chk({tag, ".aempty"},  int'(d0_aempty),  int'(lvl <= AEN));
        chk({tag, ".ovf"},     int'(d0_ovf),     int'(m_ovf));
        chk({tag, ".unf"},     int'(d0_unf),     int'(m_unf));
        chk({tag, ".rd_data"}, int'(d0_rd_data), int'(m_rd));
        chk({tag, ".f_level"}, int'(d1_level),   lvl);
        chk({tag, ".f_empty"}, int'(d1_empty),   int'(lvl == 0));
        chk({tag, ".f_ovf"},   int'(d1_ovf),     int'(m_ovf));
        chk({tag, ".f_unf"},   int'(d1_unf),     int'(m_unf));
        if (lvl != 0) chk({tag, ".f_rd_data"}, int'(d1_rd_data), int'(exp_q[0]));
    endtask

    // driver: apply one cycle of requests, sample #1 after the edge
    task automatic step(input bit f, input bit w, input bit r, input logic [DW-1:0] d, input string tag);
        flush = f; wr_en = w; rd_en = r; wr_data = d;
        @(posedge clk);
        #1;
        model_step(f, w, r, d);
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check_model(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".empty"},   int'(d0_empty),   1);
        chk({tag, ".aempty"},  int'(d0_aempty),  1);
        chk({tag, ".full"},    int'(d0_full),    0);
        chk({tag, ".afull"},   int'(d0_afull),   0);
        chk({tag, ".level"},   int'(d0_level),   0);
        chk({tag, ".ovf"},     int'(d0_ovf),     0);
        chk({tag, ".unf"},     int'(d0_unf),     0);
        chk({tag, ".rd_data"}, int'(d0_rd_data), 0);
        chk({tag, ".f_empty"}, int'(d1_empty),   1);
        chk({tag, ".f_rd_data"}, int'(d1_rd_data), 0);
    endtask

    typedef struct {
        bit            f, w, r;
        logic [DW-1:0] d;
        int            lvl;
        bit            afull, full, aempty, empty, ovf, unf;
        logic [DW-1:0] rdat;
    } vec_t;

    function automatic vec_t mk(input bit w, input bit r, input logic [DW-1:0] d, input int lvl,
                                input bit ovf, input bit unf, input logic [DW-1:0] rdat);
        vec_t v;
        v.f = 1'b0; v.w = w; v.r = r; v.d = d; v.lvl = lvl;
        v.afull = (lvl >= AFN); v.full = (lvl == DEP);
        v.aempty = (lvl <= AEN); v.empty = (lvl == 0);
        v.ovf = ovf; v.unf = unf; v.rdat = rdat;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int lvl, op;
        rst_n = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // fill 17 words then drain 17 reads: table of explicit expectations
        for (int i = 0; i < 17; i++) begin
            lvl = (i + 1 > DEP) ? DEP : i + 1;
            tbl.push_back(mk(1'b1, 1'b0, DW'(i + 1), lvl, i == 16, 1'b0, 16'h0000));
        end
        for (int i = 0; i < 17; i++) begin
            lvl = (i < 16) ? 15 - i : 0;
            tbl.push_back(mk(1'b0, 1'b1, 16'h0000, lvl, 1'b1, i == 16, (i < 16) ? DW'(i + 1) : 16'h0010));
        end
        foreach (tbl[k]) begin
            step(tbl[k].f, tbl[k].w, tbl[k].r, tbl[k].d, "vec");
            chk("vec.level",   int'(d0_level),   tbl[k].lvl);
            chk("vec.afull",   int'(d0_afull),   int'(tbl[k].afull));
            chk("vec.full",    int'(d0_full),    int'(tbl[k].full));
            chk("vec.aempty",  int'(d0_aempty),  int'(tbl[k].aempty));
            chk("vec.empty",   int'(d0_empty),   int'(tbl[k].empty));
            chk("vec.ovf",     int'(d0_ovf),     int'(tbl[k].ovf));
            chk("vec.unf",     int'(d0_unf),     int'(tbl[k].unf));
            chk("vec.rd_data", int'(d0_rd_data), int'(tbl[k].rdat));
        end

        // simultaneous requests at mid level, full and empty
        step(1'b1, 1'b0, 1'b0, 16'h0, "sim_flush");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom), "sim_w");
        step(1'b0, 1'b1, 1'b1, 16'h1111, "sim_mid");
        chk("sim_mid.level", int'(d0_level), 5);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom), "sim_fill");
        step(1'b0, 1'b1, 1'b1, 16'h2222, "sim_full");
        chk("sim_full.level", int'(d0_level), 15);
        chk("sim_full.ovf",   int'(d0_ovf),   1);
        step(1'b1, 1'b0, 1'b0, 16'h0, "sim_flush2");
        step(1'b0, 1'b1, 1'b1, 16'h3333, "sim_empty");
        chk("sim_empty.level", int'(d0_level), 1);
        chk("sim_empty.unf",   int'(d0_unf),   1);

        // pointer wrap with level kept between 3 and 9
        step(1'b1, 1'b0, 1'b0, 16'h0, "wrap_flush");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom), "wrap_pre");
        for (int i = 0; i < 40; i++) begin
            lvl = exp_q.size();
            if (lvl <= 3)      op = 0;
            else if (lvl >= 9) op = 1;
            else               op = $urandom_range(0, 2);
            step(1'b0, op != 1, op != 0, DW'($urandom), "wrap");
        end

        // FWFT: word falls through to the output with no read request
        step(1'b1, 1'b0, 1'b0, 16'h0, "fwft_flush");
        step(1'b0, 1'b1, 1'b0, 16'hABCD, "fwft");
        chk("fwft.empty",   int'(d1_empty),   0);
        chk("fwft.rd_data", int'(d1_rd_data), 16'hABCD);

        // flush with wr_en at level 7 while overflow is set
        step(1'b1, 1'b0, 1'b0, 16'h0, "fl_flush");
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom), "fl_fill");
        for (int i = 0; i < 9; i++)  step(1'b0, 1'b0, 1'b1, 16'h0, "fl_drain");
        chk("fl_pre.level", int'(d0_level), 7);
        chk("fl_pre.ovf",   int'(d0_ovf),   1);
        step(1'b1, 1'b1, 1'b0, 16'hDEAD, "fl");
        chk("fl.level", int'(d0_level), 0);
        chk("fl.empty", int'(d0_empty), 1);
        chk("fl.ovf",   int'(d0_ovf),   0);

        // reset mid-burst, then a write in the first cycle after release
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, DW'(16'h7000 + i), "rb_w");
        step(1'b0, 1'b1, 1'b1, 16'h7003, "rb_wr");
        wr_en = 1'b1; wr_data = 16'h7777;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_values("rst_mid");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 16'h5A5A, "rst_rel");
        chk("rst_rel.level", int'(d0_level), 1);
        step(1'b0, 1'b0, 1'b1, 16'h0, "rst_rd");
        chk("rst_rd.rd_data", int'(d0_rd_data), 16'h5A5A);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, DW'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_pix_fifo.md
LCD_PIX_FIFO -- requirements
Module: lcd_pix_fifo

Interface
REQ-001 The block SHALL take these parameters:
- DATA_WIDTH, default 16, word width (1..1152).
- DEPTH_WIDTH, default 11, log2 of depth, giving DEPTH = 2^DEPTH_WIDTH (4..20).
- FWFT, default 0, 0 = standard read, 1 = first-word-fall-through.
- ALMOST_FULL_NUM, default 640, almost_full threshold (1..DEPTH).
- ALMOST_EMPTY_NUM, default 4, almost_empty threshold (0..DEPTH-1).

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- full  out  1  FIFO full.
- almost_full  out  1  level >= ALMOST_FULL_NUM.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  read word.
- empty  out  1  FIFO empty.
- almost_empty  out  1  level <= ALMOST_EMPTY_NUM.
- water_level  out  DEPTH_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Function
REQ-003 Read and write pointers SHALL be DEPTH_WIDTH+1 bits wide and wrap modulo 2*DEPTH, so full and empty are distinguishable by the MSB.
REQ-004 A write SHALL be accepted iff wr_en=1 and full=0 at the clock edge; the word is stored at wr_ptr and wr_ptr increments.
REQ-005 A read SHALL be accepted iff rd_en=1 and empty=0 at the clock edge; rd_ptr increments.
REQ-006 Acceptance SHALL use flag values at the start of the cycle. If full and both requests are asserted: the read is accepted and the write is rejected. If empty and both are asserted: the write is accepted and the read is rejected.
REQ-007 water_level SHALL be a register updated on the same edge as the pointers: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
REQ-008 full, empty, almost_full and almost_empty SHALL be registered and consistent with water_level in the same cycle (full = level==DEPTH, empty = level==0).
REQ-009 With FWFT=0, rd_data SHALL present the popped word one cycle after an accepted read, and SHALL hold its value otherwise.
REQ-010 With FWFT=1, rd_data SHALL present the word at rd_ptr whenever empty=0, and an accepted read SHALL advance to the next word. After a write into an empty FIFO, empty SHALL deassert on the next edge.
REQ-011 A rejected write SHALL set overflow; a rejected read SHALL set underflow. Both flags stay set until flush or reset.
REQ-012 flush=1 SHALL override wr_en and rd_en in that cycle, and SHALL zero pointers, water_level, overflow and underflow. Flags return to their reset values on the next edge; rd_data holds.
REQ-013 Memory contents SHALL NOT be reset; words read after reset or flush are only those written since.

Reset
REQ-014 While rst_n=0, the following SHALL be held asynchronously: empty=1, almost_empty=1 (also when ALMOST_EMPTY_NUM=0), full=0, almost_full=0, water_level=0, overflow=0, underflow=0, rd_data=0.
REQ-015 Reset asserted mid-operation SHALL discard all contents. Requests present in the first cycle after release SHALL be handled normally.

Structure
REQ-016 A shared package lcd_fifo_pkg SHALL hold the default widths, the default thresholds and a parameter-legality check function. Elaboration SHALL fail when ALMOST_FULL_NUM > DEPTH or ALMOST_EMPTY_NUM >= DEPTH.
REQ-017 Storage SHALL be one sub-module, lcd_pix_fifo_ram: a simple dual-port RAM with a registered read port for FWFT=0 and an asynchronous read port for FWFT=1. Pointer, level and flag logic SHALL stay in lcd_pix_fifo.

Verification
REQ-018 The bench SHALL cover these directed scenarios (DATA_WIDTH=16, DEPTH_WIDTH=4, ALMOST_FULL_NUM=12, ALMOST_EMPTY_NUM=2):
- Fill: write 0x0001..0x0010 -> almost_full rises at level 12 and full at level 16. A 17th write -> overflow=1 and contents unchanged.
- Drain (FWFT=0): read 16 words -> rd_data 0x0001..0x0010, each one cycle after its rd_en. almost_empty rises at level 2, empty at 0. One more read -> underflow=1.
- Simultaneous: at level 5 with wr_en=rd_en=1 -> level stays 5. When full with both asserted -> level 15 and overflow=1. When empty with both asserted -> level 1 and underflow=1.
- Wrap: 40 mixed writes and reads keeping level between 3 and 9 -> output order matches the write order across pointer wrap.
- FWFT=1: write 0xABCD into empty -> empty=0 and rd_data=0xABCD the next cycle, with no rd_en required.
- Flush/reset: at level 7 with overflow=1, assert flush together with wr_en -> level 0, empty=1, overflow=0. Asserting rst_n=0 mid-burst -> all outputs take their REQ-014 values immediately.
